// File: rtl/csa_pkg.sv
// Shared types and default sizing for the sequential slice adder arbiter.
package csa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int SLICE_W_DEF    = 9;
    localparam int NUM_SLICES_DEF = 4;

endpackage

// File: rtl/csa_slice_cin.sv
// One SLICE_W-bit adder slice with carry in and carry out.
module csa_slice_cin #(
    parameter int SLICE_W = 9
) (
    input  logic [SLICE_W-1:0] a_i,
    input  logic [SLICE_W-1:0] b_i,
    input  logic               cin_i,
    output logic [SLICE_W-1:0] sum_o,
    output logic               cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i}
                           + {{SLICE_W{1'b0}}, cin_i};

endmodule

// File: rtl/csa_seq_arb.sv
// Two-requester round-robin front end feeding a multi-cycle
// slice-serial adder; one result is in flight at a time.
module csa_seq_arb
    import csa_pkg::*;
#(
    parameter int SLICE_W    = SLICE_W_DEF,
    parameter int NUM_SLICES = NUM_SLICES_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req0_valid,
    input  logic                          req1_valid,
    output logic                          req0_ready,
    output logic                          req1_ready,
    input  logic [SLICE_W*NUM_SLICES-1:0] req0_a,
    input  logic [SLICE_W*NUM_SLICES-1:0] req0_b,
    input  logic [SLICE_W*NUM_SLICES-1:0] req1_a,
    input  logic [SLICE_W*NUM_SLICES-1:0] req1_b,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [SLICE_W*NUM_SLICES-1:0] resp_sum,
    output logic                          resp_cout,
    output logic                          resp_id,
    output logic                          busy
);

    localparam int OPW = SLICE_W * NUM_SLICES;
    localparam int KW  = $clog2(NUM_SLICES);
    localparam logic [KW-1:0] LAST = KW'(NUM_SLICES - 1);

    state_e         state_q, state_d;
    logic [KW-1:0]  k_q, k_d;
    logic           carry_q, carry_d;
    logic           rr_q, rr_d;
    logic           id_q, id_d;
    logic [OPW-1:0] a_q, a_d;
    logic [OPW-1:0] b_q, b_d;
    logic [OPW-1:0] sum_q, sum_d;

    logic               gnt0, gnt1, idle, accept;
    logic [SLICE_W-1:0] sl_a, sl_b, sl_sum;
    logic               sl_cout;

    assign gnt0   = req0_valid && (!req1_valid || !rr_q);
    assign gnt1   = req1_valid && (!req0_valid || rr_q);
    assign idle   = (state_q == IDLE);
    assign accept = idle && (req0_valid || req1_valid);

    // Gated by rst_n so no handshake is offered while held in reset.
    assign req0_ready = rst_n && idle && gnt0;
    assign req1_ready = rst_n && idle && gnt1;

    assign resp_valid = (state_q == DONE);
    assign busy       = !idle;
    assign resp_sum   = sum_q;
    assign resp_cout  = carry_q;
    assign resp_id    = id_q;

    assign sl_a = a_q[int'(k_q)*SLICE_W +: SLICE_W];
    assign sl_b = b_q[int'(k_q)*SLICE_W +: SLICE_W];

    csa_slice_cin #(
        .SLICE_W (SLICE_W)
    ) u_slice (
        .a_i    (sl_a),
        .b_i    (sl_b),
        .cin_i  (carry_q),
        .sum_o  (sl_sum),
        .cout_o (sl_cout)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        carry_d = carry_q;
        rr_d    = rr_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                    a_d     = gnt1 ? req1_a : req0_a;
                    b_d     = gnt1 ? req1_b : req0_b;
                    id_d    = gnt1;
                    rr_d    = !gnt1;
                    k_d     = '0;
                    carry_d = 1'b0;
                end
            end
            RUN: begin
                sum_d[int'(k_q)*SLICE_W +: SLICE_W] = sl_sum;
                carry_d = sl_cout;
                k_d     = k_q + KW'(1);
                if (k_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            carry_q <= 1'b0;
            rr_q    <= 1'b0;
            id_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
        end
    end

endmodule

// File: tb/tb_csa_seq_arb.sv
// Randomized and directed bench for csa_seq_arb against an
// arithmetic reference of sum, carry, grant order and timing.
module tb_csa_seq_arb;

    localparam int OPW = 36;

    logic           clk;
    logic           rst_n;
    logic           req0_valid, req1_valid;
    logic           req0_ready, req1_ready;
    logic [OPW-1:0] req0_a, req0_b, req1_a, req1_b;
    logic           resp_valid, resp_ready;
    logic [OPW-1:0] resp_sum;
    logic           resp_cout, resp_id, busy;

    int nchk = 0;
    int nerr = 0;
    int edge_cnt = 0;
    int acc_edge = 0;
    int prev_acc = 0;
    bit rr_m;

    csa_seq_arb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_sum   (resp_sum),
        .resp_cout  (resp_cout),
        .resp_id    (resp_id),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic logic [OPW-1:0] rnd36();
        return OPW'({$urandom(), $urandom()});
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered and left on a falling edge.
    task automatic txn(input bit v0, input bit v1,
                       input logic [OPW-1:0] a0, input logic [OPW-1:0] b0,
                       input logic [OPW-1:0] a1, input logic [OPW-1:0] b1,
                       input int stall, input bit keep, input bit chk_space);
        logic [OPW:0]   exp;
        logic [OPW-1:0] sum_seen;
        bit             eid;
        bit             got;
        req0_valid = v0;
        req1_valid = v1;
        req0_a = a0;
        req0_b = b0;
        req1_a = a1;
        req1_b = b1;
        resp_ready = (stall == 0);
        eid = (v0 && v1) ? rr_m : v1;
        #1;
        got = 0;
        for (int i = 0; i < 30; i++) begin
            if (req0_ready || req1_ready) begin
                got = 1;
                break;
            end
            @(negedge clk);
            #1;
        end
        check("ready_seen", 64'(got), 64'd1);
        if (!got) return;
        check("grant", {req1_ready, req0_ready}, eid ? 2'b10 : 2'b01);
        exp = eid ? ({1'b0, a1} + {1'b0, b1}) : ({1'b0, a0} + {1'b0, b0});
        rr_m = !eid;
        @(posedge clk);
        #1;
        prev_acc = acc_edge;
        acc_edge = edge_cnt;
        if (chk_space) check("spacing", 64'(acc_edge - prev_acc), 64'd6);
        if (!keep) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
        @(negedge clk);
        check("busy_run", busy, 1'b1);
        check("rdy_run", {req1_ready, req0_ready}, 2'b00);
        got = 0;
        for (int i = 0; i < 20; i++) begin
            if (resp_valid) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        check("resp_seen", 64'(got), 64'd1);
        if (!got) return;
        check("latency", 64'(edge_cnt - acc_edge), 64'd4);
        check("sum", resp_sum, exp[OPW-1:0]);
        check("cout", resp_cout, exp[OPW]);
        check("id", resp_id, eid);
        sum_seen = resp_sum;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("hold_valid", resp_valid, 1'b1);
            check("hold_sum", resp_sum, sum_seen);
            check("hold_id", resp_id, eid);
            check("hold_rdy", {req1_ready, req0_ready}, 2'b00);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("resp_drop", resp_valid, 1'b0);
    endtask

    initial begin
        bit v0, v1;
        bit got;
        rst_n = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_a = rnd36();
        req0_b = rnd36();
        req1_a = rnd36();
        req1_b = rnd36();
        resp_ready = 1'b1;
        rr_m = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", resp_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_rdy", {req1_ready, req0_ready}, 2'b00);
        check("rst_sum", resp_sum, '0);
        check("rst_id", resp_id, 1'b0);
        check("rst_cout", resp_cout, 1'b0);
        rst_n = 1'b1;

        for (int t = 0; t < 4; t++)
            txn(1, 1, rnd36(), rnd36(), rnd36(), rnd36(), 0, 1, t != 0);

        txn(1, 0, 36'hFFFFFFFFF, 36'h000000001, rnd36(), rnd36(), 0, 0, 0);
        txn(0, 1, rnd36(), rnd36(), 36'h0000001FF, 36'h000000001, 0, 0, 0);
        txn(1, 1, rnd36(), rnd36(), rnd36(), rnd36(), 10, 1, 0);

        for (int t = 0; t < 12; t++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            txn(v0, v1, rnd36(), rnd36(), rnd36(), rnd36(),
                int'($urandom_range(0, 3)), 0, 0);
        end

        req0_valid = 1'b1;
        req1_valid = 1'b0;
        req0_a = rnd36();
        req0_b = rnd36();
        #1;
        got = 0;
        for (int i = 0; i < 30; i++) begin
            if (req0_ready) begin
                got = 1;
                break;
            end
            @(negedge clk);
            #1;
        end
        check("mid_ready", 64'(got), 64'd1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        req1_valid = 1'b1;
        #1;
        check("mid_busy", busy, 1'b0);
        check("mid_valid", resp_valid, 1'b0);
        check("mid_rdy", {req1_ready, req0_ready}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        req1_valid = 1'b0;
        rr_m = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("post_valid", resp_valid, 1'b0);
            check("post_busy", busy, 1'b0);
        end
        txn(1, 1, 36'h123456789, 36'h111111111, rnd36(), rnd36(), 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/csa_seq_arb.md
CSA_SEQ_ARB -- requirements
Module: csa_seq_arb

Interface
REQ-001 SHALL have parameter SLICE_W, default 9, meaning the adder slice width in bits.
REQ-002 SHALL have parameter NUM_SLICES, default 4, meaning slices per operand; operand width OPW = SLICE_W*NUM_SLICES (36 by default).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have ports req0_valid / req1_valid, input, 1 each, meaning requester has an operand pair.
REQ-006 SHALL have ports req0_ready / req1_ready, output, 1 each, meaning the pair is accepted this cycle.
REQ-007 SHALL have ports req0_a, req0_b, req1_a, req1_b, input, OPW each, meaning the addends.
REQ-008 SHALL have port resp_valid, output, 1, meaning the result is available.
REQ-009 SHALL have port resp_ready, input, 1, meaning the consumer takes the result.
REQ-010 SHALL have port resp_sum, output, OPW, meaning the sum modulo 2^OPW.
REQ-011 SHALL have port resp_cout, output, 1, meaning the carry out of bit OPW-1.
REQ-012 SHALL have port resp_id, output, 1, meaning the index of the requester that owns the result.
REQ-013 SHALL have port busy, output, 1, meaning the state is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and DONE.
- IDLE->RUN on an accept.
- RUN->DONE after the last slice.
- DONE->IDLE on resp_valid&&resp_ready.
REQ-015 SHALL assert reqN_ready only in IDLE, only for the granted requester, combinationally from the valids and rr_ptr.
REQ-016 SHALL grant by round-robin.
- Single valid wins.
- When both are valid, requester rr_ptr wins.
- rr_ptr becomes the complement of the granted id on each accept.
REQ-017 SHALL latch a, b and id on accept, and clear slice counter k and the carry register to 0.
REQ-018 SHALL, in each RUN cycle, add slice k of a and b plus the carry register in one slice adder.
- Write the SLICE_W-bit result into slice k of the sum register.
- Load the slice carry into the carry register.
- Increment k.
REQ-019 SHALL move to DONE when k==NUM_SLICES-1 completes, so resp_valid rises exactly NUM_SLICES edges after the accepting edge.
REQ-020 SHALL hold resp_sum, resp_cout and resp_id stable while resp_valid=1 and resp_ready=0.
REQ-021 SHALL ignore request inputs outside IDLE; a request arriving during RUN or DONE waits with ready=0.
REQ-022 SHALL accept no new request in the cycle DONE is left; the earliest next accept is the following IDLE cycle.
REQ-023 SHALL drive resp_sum, resp_cout and resp_id from registers only; resp_sum SHALL be valid only while resp_valid=1.
REQ-024 SHALL wrap the sum modulo 2^OPW; overflow is reported solely via resp_cout.

Reset
REQ-025 SHALL, while rst_n=0, force:
- state IDLE, k=0, carry=0, rr_ptr=0;
- sum register 0, id register 0;
- resp_valid=0, busy=0, req0_ready=0, req1_ready=0.
REQ-026 SHALL, on rst_n assertion mid-RUN or mid-DONE, discard the operation with no response.
REQ-027 SHALL make the first accept after reset go to requester 0 if both are valid.

Structure
REQ-028 SHALL place the state enum (IDLE/RUN/DONE) and the default SLICE_W/NUM_SLICES constants in shared package csa_pkg.
REQ-029 SHALL instantiate one combinational sub-module csa_slice_cin.
- Ports: SLICE_W-bit a, b; 1-bit cin; SLICE_W-bit sum; 1-bit cout.
- It is the only adder in the block.
REQ-030 SHALL keep k at $clog2(NUM_SLICES) bits and be synthesizable for NUM_SLICES >= 2.

Verification
REQ-031 SHALL cover full carry ripple: req0 a=0xFFFFFFFFF, b=0x000000001 -> resp_sum=0x000000000, resp_cout=1, resp_id=0, resp_valid 4 edges after accept.
REQ-032 SHALL cover cross-slice carry: req1 a=0x0000001FF, b=0x000000001 -> resp_sum=0x000000200, resp_cout=0, resp_id=1.
REQ-033 SHALL cover arbitration: both valid continuously from reset, resp_ready=1.
- Grants are 0,1,0,1.
- Each accept is exactly 6 edges apart (accept, 4 RUN, DONE).
REQ-034 SHALL cover backpressure: resp_ready=0 for 10 cycles in DONE -> resp_valid, resp_sum and resp_id held; req ready stays 0; completion follows one cycle after resp_ready=1.
REQ-035 SHALL cover reset mid-operation: rst_n low after slice 2 -> resp_valid never rises; busy=0; the next request completes correctly: a=0x123456789, b=0x111111111 -> sum 0x23456789A, cout 0.
